// File: rtl/snake_pkg.sv
// Shared encodings for the snake controller: directions, ASCII keys, command
// kinds and the consumer FSM states, plus the key decoder.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [7:0] KEY_W    = 8'h77;
  localparam logic [7:0] KEY_A    = 8'h61;
  localparam logic [7:0] KEY_S    = 8'h73;
  localparam logic [7:0] KEY_D    = 8'h64;
  localparam logic [7:0] KEY_P    = 8'h70;
  localparam logic [7:0] KEY_R    = 8'h72;
  localparam logic [7:0] KEY_UC_A = 8'h41;
  localparam logic [7:0] KEY_UC_Z = 8'h5A;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_DIR,
    CMD_PAUSE,
    CMD_RESTART
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e  kind;
    logic [1:0] dir;
  } cmd_t;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_e;

  // Upper-case letters are folded to lower case; nothing else is touched.
  function automatic cmd_t decode_key(input logic [7:0] b);
    cmd_t       c;
    logic [7:0] lc;
    lc     = (b >= KEY_UC_A && b <= KEY_UC_Z) ? (b | 8'h20) : b;
    c.kind = CMD_NONE;
    c.dir  = DIR_RIGHT;
    case (lc)
      KEY_W: begin c.kind = CMD_DIR; c.dir = DIR_UP;    end
      KEY_D: begin c.kind = CMD_DIR; c.dir = DIR_RIGHT; end
      KEY_S: begin c.kind = CMD_DIR; c.dir = DIR_DOWN;  end
      KEY_A: begin c.kind = CMD_DIR; c.dir = DIR_LEFT;  end
      KEY_P: c.kind = CMD_PAUSE;
      KEY_R: c.kind = CMD_RESTART;
      default: c.kind = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for queued direction keys. A push to a full FIFO is
// accepted only when a pop happens in the same cycle; flush empties it.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int PTR_W = 2
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART-to-game command controller: byte edge capture, key decode, pause and
// overflow flags, and the per-tick direction consumer.
module uart_cmd_ctrl
  import snake_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       i_rx_wr,
  input  logic [7:0] i_rx_data,
  input  logic       i_tick,
  input  logic       i_clr_err,
  output logic [1:0] o_dir,
  output logic       o_dir_valid,
  output logic       o_pause,
  output logic       o_restart,
  output logic       o_overflow
);

  logic       r_wr_q;
  logic [1:0] r_dir;
  logic       r_dir_valid;
  logic       r_pause;
  logic       r_restart;
  logic       r_overflow;
  state_e     r_state;

  logic       w_accept;
  cmd_t       w_cmd;
  logic       w_push;
  logic       w_pause_tgl;
  logic       w_restart;
  logic       w_pop;
  logic [1:0] w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_head_legal;
  logic       w_overflow_set;

  // The receiver holds i_rx_wr for many cycles; only its rising edge counts.
  assign w_accept    = i_rx_wr & ~r_wr_q;
  assign w_cmd       = decode_key(i_rx_data);
  assign w_push      = w_accept & (w_cmd.kind == CMD_DIR);
  assign w_pause_tgl = w_accept & (w_cmd.kind == CMD_PAUSE);
  assign w_restart   = w_accept & (w_cmd.kind == CMD_RESTART);

  assign w_pop          = (r_state == ST_SCAN) & ~w_empty & ~w_restart;
  assign w_head_legal   = (w_head != r_dir) && (w_head != (r_dir ^ 2'b10));
  assign w_overflow_set = w_push & w_full & ~w_pop;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2),
    .PTR_W (PTR_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_restart),
    .i_din   (w_cmd.dir),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      r_wr_q      <= 1'b0;
      r_dir       <= DIR_RIGHT;
      r_dir_valid <= 1'b0;
      r_pause     <= 1'b0;
      r_restart   <= 1'b0;
      r_overflow  <= 1'b0;
      r_state     <= ST_IDLE;
    end else begin
      r_wr_q      <= i_rx_wr;
      r_dir_valid <= 1'b0;
      r_restart   <= 1'b0;

      if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end

      // Restart overrides whatever the consumer would do this cycle.
      if (w_restart) begin
        r_restart <= 1'b1;
        r_dir     <= DIR_RIGHT;
        r_pause   <= 1'b0;
        r_state   <= ST_IDLE;
      end else begin
        if (w_pause_tgl) begin
          r_pause <= ~r_pause;
        end
        case (r_state)
          ST_IDLE: begin
            if (i_tick && !r_pause) begin
              r_state <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (w_empty) begin
              r_state <= ST_IDLE;
            end else if (w_head_legal) begin
              r_dir       <= w_head;
              r_dir_valid <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_dir       = r_dir;
  assign o_dir_valid = r_dir_valid;
  assign o_pause     = r_pause;
  assign o_restart   = r_restart;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a queue-based key model predicts every
// direction/restart pulse (value and cycle) and the pause/overflow levels.
module tb_uart_cmd_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_wr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] o_dir;
  logic       o_dir_valid;
  logic       o_pause;
  logic       o_restart;
  logic       o_overflow;

  uart_cmd_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
    .i_clk       (clk),
    .rst         (rst_n),
    .i_rx_wr     (rx_wr),
    .i_rx_data   (rx_data),
    .i_tick      (tick),
    .i_clr_err   (clr),
    .o_dir       (o_dir),
    .o_dir_valid (o_dir_valid),
    .o_pause     (o_pause),
    .o_restart   (o_restart),
    .o_overflow  (o_overflow)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         is_restart;
    logic [1:0] dir;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [1:0] m_q[$];
  logic [1:0] m_dir = 2'b01;
  bit         m_pause = 1'b0;
  bit         m_ov = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  exp_t       mon_e;
  logic [1:0] prev_dir = 2'b01;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dir = 2'b01;
    end else begin
      if (o_dir_valid || o_restart) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: valid=%0b restart=%0b dir=%0d at cycle %0d, expected none",
                   o_dir_valid, o_restart, o_dir, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_is_restart", int'(o_restart), int'(mon_e.is_restart));
          check("pulse_cycle", cyc, mon_e.at);
          check("pulse_dir", int'(o_dir), int'(mon_e.dir));
          if (mon_e.is_restart) begin
            check("restart_no_valid", int'(o_dir_valid), 0);
            check("restart_pause", int'(o_pause), 0);
          end
        end
      end else if (o_dir !== prev_dir) begin
        n_cmp++;
        n_bad++;
        $display("FAIL silent_dir_change: got %0d, expected %0d (cycle %0d)", o_dir, prev_dir, cyc);
      end
      prev_dir = o_dir;
    end
  end

  task automatic model_key(input logic [7:0] b, input int acc_cyc);
    logic [7:0] lc;
    logic [1:0] d;
    bit         is_dir;
    lc = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
    is_dir = 1'b1;
    d = 2'b00;
    case (lc)
      8'h77: d = 2'b00;
      8'h64: d = 2'b01;
      8'h73: d = 2'b10;
      8'h61: d = 2'b11;
      default: is_dir = 1'b0;
    endcase
    if (is_dir) begin
      if (m_q.size() >= DEPTH) m_ov = 1'b1;
      else m_q.push_back(d);
    end else if (lc == 8'h70) begin
      m_pause = !m_pause;
    end else if (lc == 8'h72) begin
      m_q.delete();
      m_dir = 2'b01;
      m_pause = 1'b0;
      exp_q.push_back('{1'b1, 2'b01, acc_cyc + 1});
    end
  endtask

  task automatic model_tick(input int t);
    int         k;
    logic [1:0] h;
    k = 0;
    if (!m_pause) begin
      while (m_q.size() > 0) begin
        h = m_q.pop_front();
        if (h == m_dir || h == (m_dir ^ 2'b10)) begin
          k++;
        end else begin
          m_dir = h;
          exp_q.push_back('{1'b0, h, t + 2 + k});
          break;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_wr = 1'b1;
    model_key(b, cyc);
    repeat (hold) @(posedge clk);
    #1;
    rx_wr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_tick();
    @(posedge clk);
    #1;
    tick = 1'b1;
    model_tick(cyc);
    @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (DEPTH + 4) @(posedge clk);
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1;
    clr = 1'b1;
    m_ov = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_levels(input string tag);
    #1;
    check({tag, "_dir"}, int'(o_dir), int'(m_dir));
    check({tag, "_pause"}, int'(o_pause), int'(m_pause));
    check({tag, "_overflow"}, int'(o_overflow), int'(m_ov));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [7:0] keys [8];
  logic [7:0] b;

  initial begin
    keys = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h57, 8'h41, 8'h53, 8'h44};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_dir", int'(o_dir), 1);
    check("rst_dir_valid", int'(o_dir_valid), 0);
    check("rst_pause", int'(o_pause), 0);
    check("rst_restart", int'(o_restart), 0);
    check("rst_overflow", int'(o_overflow), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_tick();
    check_levels("idle_tick");

    // Long-held 'w' is accepted once
    send(8'h77, 200);
    do_tick();
    check_levels("w_long");
    do_tick();

    // Reversal discarded, then DOWN applied; FIFO left empty
    send(8'h72, 4);
    send(8'h61, 3);
    send(8'h73, 3);
    do_tick();
    check_levels("rev");
    do_tick();
    check_levels("rev_empty");

    // Overflow on the fifth key, then drain in order
    send(8'h61, 2);
    send(8'h77, 2);
    send(8'h64, 2);
    send(8'h73, 2);
    check_levels("fill4");
    send(8'h41, 2);
    check_levels("fill5");
    for (int i = 0; i < 4; i++) begin
      do_tick();
      check_levels("drain");
    end
    do_clr();
    check_levels("clr");

    // Pause holds the queue
    send(8'h52, 2);
    send(8'h50, 2);
    send(8'h64, 2);
    do_tick();
    do_tick();
    check_levels("paused");
    send(8'h70, 2);
    do_tick();
    check_levels("unpaused");
    send(8'h53, 2);
    do_tick();
    check_levels("after_s");

    // Restart flushes queued keys
    send(8'h77, 2);
    send(8'h61, 2);
    send(8'h64, 2);
    send(8'h52, 2);
    check_levels("restart");
    do_tick();
    check_levels("restart_empty");

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r <= 4) begin
        send(keys[$urandom_range(0, 7)], $urandom_range(1, 12));
      end else if (r == 5) begin
        send(($urandom_range(0, 1) == 1) ? 8'h70 : 8'h50, $urandom_range(1, 6));
      end else if (r == 6) begin
        if ($urandom_range(0, 3) == 0)
          send(($urandom_range(0, 1) == 1) ? 8'h72 : 8'h52, $urandom_range(1, 6));
        else
          do_tick();
      end else if (r <= 9) begin
        do_tick();
      end else if (r == 10) begin
        do_clr();
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h77 || b == 8'h61 || b == 8'h73 || b == 8'h64 || b == 8'h70 || b == 8'h72 ||
            b == 8'h57 || b == 8'h41 || b == 8'h53 || b == 8'h44 || b == 8'h50 || b == 8'h52)
          b = 8'h31;
        send(b, $urandom_range(1, 6));
      end
      check_levels("rand");
    end

    // Async reset in the middle of a SCAN
    send(8'h52, 2);
    send(8'h77, 2);
    do_tick();
    for (int i = 0; i < 5; i++) send(8'h77, 2);
    check_levels("pre_rst");
    @(posedge clk);
    #1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check("midscan_dir", int'(o_dir), 1);
    check("midscan_valid", int'(o_dir_valid), 0);
    check("midscan_pause", int'(o_pause), 0);
    check("midscan_restart", int'(o_restart), 0);
    check("midscan_overflow", int'(o_overflow), 0);
    m_q.delete();
    m_dir = 2'b01;
    m_pause = 1'b0;
    m_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_tick();
    check_levels("post_rst");

    repeat (10) @(posedge clk);
    check("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
